input_conditioner: RTL

INPUT_CONDITIONER -- requirements
Module: input_conditioner

---
 rtl/input_conditioner.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/input_conditioner.sv
// rtl/input_conditioner.sv - synchronise, debounce and edge-detect board keys and switches
// Optional macro KEY_AUTO_REPEAT_EN adds hold-to-repeat key_press pulses.
module input_conditioner #(
    parameter int NUM_KEYS        = 4,
    parameter int NUM_SWITCHES    = 10,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int KEY_ACTIVE_LOW  = 1,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [NUM_KEYS-1:0]     key_raw,
    input  logic [NUM_SWITCHES-1:0] switch_raw,
    output logic [NUM_KEYS-1:0]     key_level,
    output logic [NUM_KEYS-1:0]     key_press,
    output logic [NUM_KEYS-1:0]     key_release,
    output logic [NUM_SWITCHES-1:0] switch_level,
    output logic [NUM_SWITCHES-1:0] switch_changed
);
    localparam int CH = NUM_KEYS + NUM_SWITCHES;
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [NUM_KEYS-1:0] KEY_IDLE =
        (KEY_ACTIVE_LOW != 0) ? {NUM_KEYS{1'b1}} : {NUM_KEYS{1'b0}};
    // Released value of every raw pin; also the mask that makes keys active-high.
    localparam logic [CH-1:0] RAW_IDLE = {{NUM_SWITCHES{1'b0}}, KEY_IDLE};

    logic [CH-1:0]       sync1_q, sync2_q, sample_q;
    logic [CH-1:0]       level_q, level_d, toggle;
    logic [CW-1:0]       cnt_q [CH];
    logic [CW-1:0]       cnt_d [CH];
    logic [NUM_KEYS-1:0] key_press_q, key_press_d;
    logic [NUM_KEYS-1:0] key_release_q, key_release_d;
    logic [NUM_SWITCHES-1:0] switch_changed_q, switch_changed_d;
    logic [NUM_KEYS-1:0] rpt_fire;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_q  <= RAW_IDLE;
            sync2_q  <= RAW_IDLE;
            sample_q <= '0;
        end else begin
            sync1_q  <= {switch_raw, key_raw};
            sync2_q  <= sync1_q;
            sample_q <= sync2_q ^ RAW_IDLE;
        end
    end

    // A channel toggles on its DEBOUNCE_CYCLES-th consecutive differing sample.
    always_comb begin
        toggle = '0;
        for (int i = 0; i < CH; i++) begin
            cnt_d[i] = '0;
            if (sample_q[i] != level_q[i]) begin
                if (cnt_q[i] >= CNT_LAST) begin
                    toggle[i] = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
        level_d = level_q ^ toggle;
    end

    always_comb begin
        key_press_d      = (toggle[NUM_KEYS-1:0] & level_d[NUM_KEYS-1:0]) | rpt_fire;
        key_release_d    = toggle[NUM_KEYS-1:0] & ~level_d[NUM_KEYS-1:0];
        switch_changed_d = toggle[CH-1:NUM_KEYS];
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < CH; i++) begin
                cnt_q[i] <= '0;
            end
            level_q          <= '0;
            key_press_q      <= '0;
            key_release_q    <= '0;
            switch_changed_q <= '0;
        end else begin
            for (int i = 0; i < CH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            level_q          <= level_d;
            key_press_q      <= key_press_d;
            key_release_q    <= key_release_d;
            switch_changed_q <= switch_changed_d;
        end
    end

`ifdef KEY_AUTO_REPEAT_EN
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW = $clog2(RPT_MAX + 1);
    localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD - 1);

    logic [RW-1:0]       rpt_q [NUM_KEYS];
    logic [RW-1:0]       rpt_d [NUM_KEYS];
    logic [NUM_KEYS-1:0] armed_q, armed_d;

    // armed_q marks that the initial delay has elapsed and the period phase is running.
    always_comb begin
        rpt_fire = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            rpt_d[i]   = '0;
            armed_d[i] = 1'b0;
            if (level_q[i] && !toggle[i]) begin
                armed_d[i] = armed_q[i];
                if (!armed_q[i] && rpt_q[i] >= DELAY_LAST) begin
                    rpt_fire[i] = 1'b1;
                    armed_d[i]  = 1'b1;
                end else if (armed_q[i] && rpt_q[i] >= PERIOD_LAST) begin
                    rpt_fire[i] = 1'b1;
                end else begin
                    rpt_d[i] = rpt_q[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_KEYS; i++) begin
                rpt_q[i] <= '0;
            end
            armed_q <= '0;
        end else begin
            for (int i = 0; i < NUM_KEYS; i++) begin
                rpt_q[i] <= rpt_d[i];
            end
            armed_q <= armed_d;
        end
    end
`else
    assign rpt_fire = '0;
`endif

    assign key_level      = level_q[NUM_KEYS-1:0];
    assign switch_level   = level_q[CH-1:NUM_KEYS];
    assign key_press      = key_press_q;
    assign key_release    = key_release_q;
    assign switch_changed = switch_changed_q;

endmodule
